// File: rtl/l1_refill_ctrl.sv
// ---------------------------------------------------------------------------
// l1_refill_ctrl
//
// Miss handler between the CPU data port, a direct-mapped L1 data cache and
// backing memory. A read miss refills the whole line one word at a time
// through the cache fill interface. Stores are write-through / no-allocate:
// every store is forwarded to memory and the CPU waits until it is accepted.
// Only one memory transaction is in flight at any time.
//
// Optional feature macro: L1_REFILL_CRITICAL_WORD_FIRST_EN
//   defined   : refill starts at the word addressed by the CPU and wraps
//   undefined : refill always runs word 0 .. WORDS_PER_LINE-1
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   cpu_valid        CPU request present
//   cpu_we           1 = store, 0 = load
//   cpu_addr         word-aligned byte address
//   cpu_w_data       store data
//   cache_hit        L1 hit flag for cpu_addr
//   stall            freeze the CPU
//   fill_en          write fill_data into the cache at fill_addr
//   fill_addr        word address being filled
//   fill_data        fill word
//   fill_mark_valid  set tag/valid, only with the final word of the line
//   dram_rd_en       one-cycle read request pulse
//   dram_rd_addr     read word address
//   dram_rd_data     read data
//   dram_rd_valid    read data valid (at least one cycle after the request)
//   dram_wr_en       write request, held until accepted
//   dram_wr_addr     write address
//   dram_wr_data     write data
//   dram_wr_ready    write accepted when high together with dram_wr_en
// ---------------------------------------------------------------------------
module l1_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_w_data,
  input  logic                  cache_hit,
  output logic                  stall,
  output logic                  fill_en,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_mark_valid,
  output logic                  dram_rd_en,
  output logic [ADDR_WIDTH-1:0] dram_rd_addr,
  input  logic [DATA_WIDTH-1:0] dram_rd_data,
  input  logic                  dram_rd_valid,
  output logic                  dram_wr_en,
  output logic [ADDR_WIDTH-1:0] dram_wr_addr,
  output logic [DATA_WIDTH-1:0] dram_wr_data,
  input  logic                  dram_wr_ready
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int WORDS_PER_LINE = LINE_SIZE / BYTES_PER_WORD;
  localparam int OFFSET_BITS    = $clog2(LINE_SIZE);
  localparam int BYTE_BITS      = $clog2(BYTES_PER_WORD);
  localparam int IDX_BITS       = $clog2(WORDS_PER_LINE);
  localparam int TAG_BITS       = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    FILL,
    DONE,
    WR
  } state_t;

  state_t state, next_state;

  logic [TAG_BITS-1:0]   line_tag;
  logic [IDX_BITS-1:0]   word_cnt;
  logic [IDX_BITS-1:0]   start_idx;
  logic [IDX_BITS-1:0]   word_idx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic [DATA_WIDTH-1:0] fill_data_q;
  logic                  fill_last_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic read_miss;
  logic store_req;

  // Offset bits of the CPU address are only partly consumed (and not at all
  // in the default build); collected here so they read as intentionally unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[OFFSET_BITS-1:0];

  assign read_miss = cpu_valid & ~cpu_we & ~cache_hit;
  assign store_req = cpu_valid & cpu_we;

  // word_cnt counts fetched words; the index actually fetched is offset by
  // start_idx and wraps inside the line because it is only IDX_BITS wide.
  assign word_idx  = start_idx + word_cnt;
  assign cur_addr  = {line_tag, word_idx, {BYTE_BITS{1'b0}}};
  assign last_word = (word_cnt == IDX_BITS'(WORDS_PER_LINE - 1));

`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
  logic [IDX_BITS-1:0] start_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_idx_q <= '0;
    end else if (state == IDLE && !store_req && read_miss) begin
      start_idx_q <= cpu_addr[OFFSET_BITS-1:BYTE_BITS];
    end
  end

  assign start_idx = start_idx_q;
`else
  assign start_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      line_tag    <= '0;
      word_cnt    <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      fill_last_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (store_req) begin
            wr_addr_q <= cpu_addr;
            wr_data_q <= cpu_w_data;
          end else if (read_miss) begin
            line_tag <= cpu_addr[ADDR_WIDTH-1:OFFSET_BITS];
            word_cnt <= '0;
          end
        end
        RD_WAIT: begin
          if (dram_rd_valid) begin
            fill_addr_q <= cur_addr;
            fill_data_q <= dram_rd_data;
            fill_last_q <= last_word;
          end
        end
        FILL: begin
          if (!last_word) begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    next_state   = state;
    stall        = 1'b0;
    fill_en      = 1'b0;
    dram_rd_en   = 1'b0;
    dram_rd_addr = '0;
    dram_wr_en   = 1'b0;
    dram_wr_addr = '0;
    dram_wr_data = '0;
    case (state)
      IDLE: begin
        if (store_req) begin
          stall      = 1'b1;
          next_state = WR;
        end else if (read_miss) begin
          stall      = 1'b1;
          next_state = RD_REQ;
        end
      end
      RD_REQ: begin
        stall        = 1'b1;
        dram_rd_en   = 1'b1;
        dram_rd_addr = cur_addr;
        next_state   = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (dram_rd_valid) begin
          next_state = FILL;
        end
      end
      FILL: begin
        stall      = 1'b1;
        fill_en    = 1'b1;
        next_state = last_word ? DONE : RD_REQ;
      end
      WR: begin
        stall        = 1'b1;
        dram_wr_en   = 1'b1;
        dram_wr_addr = wr_addr_q;
        dram_wr_data = wr_data_q;
        if (dram_wr_ready) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The last-word flag is qualified by fill_en so the tag/valid update can
  // only coincide with the final fill write of a completed line.
  assign fill_addr       = fill_addr_q;
  assign fill_data       = fill_data_q;
  assign fill_mark_valid = fill_en & fill_last_q;

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Testbench for l1_refill_ctrl: DRAM model with programmable read latency and
// write-accept delay, scoreboard queues filled when each request is driven
// and drained as the DUT produces memory / fill activity.
module tb_l1_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_w_data = '0;
  logic        cache_hit = 1'b0;
  logic        stall;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        fill_mark_valid;
  logic        dram_rd_en;
  logic [31:0] dram_rd_addr;
  logic [31:0] dram_rd_data = '0;
  logic        dram_rd_valid = 1'b0;
  logic        dram_wr_en;
  logic [31:0] dram_wr_addr;
  logic [31:0] dram_wr_data;
  logic        dram_wr_ready;

  l1_refill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LINE_SIZE(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_valid      (cpu_valid),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_w_data     (cpu_w_data),
    .cache_hit      (cache_hit),
    .stall          (stall),
    .fill_en        (fill_en),
    .fill_addr      (fill_addr),
    .fill_data      (fill_data),
    .fill_mark_valid(fill_mark_valid),
    .dram_rd_en     (dram_rd_en),
    .dram_rd_addr   (dram_rd_addr),
    .dram_rd_data   (dram_rd_data),
    .dram_rd_valid  (dram_rd_valid),
    .dram_wr_en     (dram_wr_en),
    .dram_wr_addr   (dram_wr_addr),
    .dram_wr_data   (dram_wr_data),
    .dram_wr_ready  (dram_wr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        mark;
  } fill_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
  } wr_t;

  resp_t       resp_q[$];
  logic [31:0] exp_rd_q[$];
  fill_t       exp_fill_q[$];
  wr_t         exp_wr_q[$];
  int          exp_stall_q[$];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int lat = 1;
  int wr_delay = 0;
  int wr_wait = 0;
  int fill_seen = 0;
  int stall_cnt = 0;
  int last_rd_cyc = 0;
  int wr_cycles = 0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // DRAM read side: responses become visible lat cycles after the request
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      dram_rd_valid = 1'b1;
      dram_rd_data  = memData(resp_q[0].addr);
      void'(resp_q.pop_front());
    end else begin
      dram_rd_valid = 1'b0;
      dram_rd_data  = '0;
    end
  end

  // DRAM write side: refuses wr_delay cycles, then accepts
  assign dram_wr_ready = dram_wr_en && (wr_wait >= wr_delay);

  always @(posedge clk) begin
    if (dram_wr_en && !dram_wr_ready) wr_wait <= wr_wait + 1;
    else wr_wait <= 0;
  end

  // Monitor / scoreboard, sampled mid-cycle
  fill_t mf;
  wr_t   mw;
  resp_t mr;

  always @(negedge clk) begin
    if (!rst) begin
      if (dram_rd_en) begin
        mr.due  = cyc + lat;
        mr.addr = dram_rd_addr;
        resp_q.push_back(mr);
        if (exp_rd_q.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
        else checkOutput("rd_addr", dram_rd_addr, exp_rd_q.pop_front());
        last_rd_cyc = cyc;
      end
      if (fill_en) begin
        fill_seen++;
        if (exp_fill_q.size() == 0) begin
          checkOutput("fill_unexpected", 32'd1, 32'd0);
        end else begin
          mf = exp_fill_q.pop_front();
          checkOutput("fill_addr", fill_addr, mf.addr);
          checkOutput("fill_data", fill_data, mf.data);
          checkOutput("fill_mark", {31'd0, fill_mark_valid}, {31'd0, mf.mark});
          checkOutput("rd_to_fill", cyc - last_rd_cyc, lat + 1);
        end
      end else if (fill_mark_valid) begin
        checkOutput("mark_without_fill", 32'd1, 32'd0);
      end
      if (dram_wr_en) begin
        wr_cycles++;
        if (exp_wr_q.size() == 0) begin
          checkOutput("wr_unexpected", 32'd1, 32'd0);
        end else begin
          mw = exp_wr_q[0];
          checkOutput("wr_addr", dram_wr_addr, mw.addr);
          checkOutput("wr_data", dram_wr_data, mw.data);
          if (dram_wr_ready) begin
            checkOutput("wr_hold", wr_cycles, mw.hold);
            void'(exp_wr_q.pop_front());
            wr_cycles = 0;
          end
        end
      end
      if (stall) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (exp_stall_q.size() > 0) checkOutput("stall_len", stall_cnt, exp_stall_q.pop_front());
        stall_cnt = 0;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic hit);
    @(posedge clk);
    #1;
    cpu_valid  = v;
    cpu_we     = we;
    cpu_addr   = a;
    cpu_w_data = d;
    cache_hit  = hit;
  endtask

  task automatic waitStallLow(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!stall) return;
    end
    checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic pushMiss(input logic [31:0] a, input int l);
    logic [1:0]  start;
    logic [1:0]  w;
    logic [31:0] wa;
    fill_t       f;
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
    start = a[3:2];
`else
    start = 2'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      w  = start + 2'(k);
      wa = {a[31:4], w, 2'b00};
      exp_rd_q.push_back(wa);
      f.addr = wa;
      f.data = memData(wa);
      f.mark = (k == 3);
      exp_fill_q.push_back(f);
    end
    exp_stall_q.push_back(1 + 4 * (l + 2));
  endtask

  task automatic runMiss(input logic [31:0] a, input int l);
    lat = l;
    pushMiss(a, l);
    applyStimulus(1'b1, 1'b0, a, 32'd0, 1'b0);
    waitStallLow("miss");
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("miss_rd_left", exp_rd_q.size(), 32'd0);
    checkOutput("miss_fill_left", exp_fill_q.size(), 32'd0);
  endtask

  task automatic runStore(input logic [31:0] a, input logic [31:0] d, input int dly);
    wr_t w;
    wr_delay = dly;
    w.addr = a;
    w.data = d;
    w.hold = dly + 1;
    exp_wr_q.push_back(w);
    exp_stall_q.push_back(dly + 2);
    applyStimulus(1'b1, 1'b1, a, d, 1'b0);
    waitStallLow("store");
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("store_left", exp_wr_q.size(), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {27'd0, stall, fill_en, fill_mark_valid, dram_rd_en, dram_wr_en}, 32'd0);
    checkOutput({tag, "_fill_addr"}, fill_addr, 32'd0);
    checkOutput({tag, "_fill_data"}, fill_data, 32'd0);
    checkOutput({tag, "_rd_addr"}, dram_rd_addr, 32'd0);
    checkOutput({tag, "_wr_addr"}, dram_wr_addr, 32'd0);
    checkOutput({tag, "_wr_data"}, dram_wr_data, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    resp_t       sp;
    int          base;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    // Load miss, latency 1
    runMiss(32'h0000_1234, 1);

    // Load hit with a stray read response arriving in IDLE
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'd0, 1'b1);
    sp.due  = cyc + 2;
    sp.addr = 32'h0000_2000;
    resp_q.push_back(sp);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("hit_stall", {31'd0, stall}, 32'd0);
      checkOutput("hit_rd_fill", {30'd0, dram_rd_en, fill_en}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Stores: delayed acceptance and immediate acceptance
    runStore(32'h0000_0040, 32'hDEAD_BEEF, 3);
    runStore(32'h0000_0084, 32'h1234_5678, 0);

    // Reset while waiting for the third word
    lat = 3;
    pushMiss(32'h0000_1234, 3);
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, 32'd0, 1'b0);
    base = fill_seen;
    for (int i = 0; i < 200 && fill_seen < base + 2; i++) @(negedge clk);
    checkOutput("abort_fills_seen", fill_seen - base, 32'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_valid = 1'b0;
    exp_rd_q.delete();
    exp_fill_q.delete();
    exp_stall_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    repeat (6) @(negedge clk);
    checkOutput("abort_idle_stall", {31'd0, stall}, 32'd0);

    // Same line again must restart from the beginning
    runMiss(32'h0000_1234, 1);

    // Long latency
    runMiss(32'h0000_ABC8, 5);

    // A few arbitrary lines
    for (int i = 0; i < 3; i++) begin
      ra = $urandom();
      ra[1:0] = 2'b00;
      runMiss(ra, 1 + i);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
